// File: rtl/seg_scan_controller.sv
// Scans a 4-digit 7-segment display, swapping the shown value only at frame ends.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_controller #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [15:0] cpu_val,
  input  logic        cpu_we,
  input  logic [15:0] dbg_val,
  input  logic        sel_dbg,
  output logic [7:0]  Cathodes,
  output logic [3:0]  AN,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [15:0]   cpu_reg;
  logic [15:0]   shown;
  logic [CW-1:0] div_cnt;
  logic [1:0]    digit;

  logic          wrap;
  logic          boundary;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic          blank;
  logic [3:0]    an_nx;
  logic [7:0]    cat_nx;

  assign wrap     = (div_cnt == LAST);
  assign boundary = wrap && (digit == 2'd3);
  assign nib      = shown[4*digit +: 4];

  always_comb begin
    seg = 7'h7F;
    unique case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    blank = 1'b0;
    unique case (digit)
      2'd3: blank = (shown[15:12] == 4'h0);
      2'd2: blank = (shown[15:8] == 8'h00);
      2'd1: blank = (shown[15:4] == 12'h000);
      2'd0: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_nx  = 4'b1111;
    cat_nx = 8'hFF;
    if (div_cnt != '0) begin
      an_nx = ~(4'b0001 << digit);
      if (!blank) cat_nx = {1'b1, seg};
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      cpu_reg    <= '0;
      shown      <= '0;
      div_cnt    <= '0;
      digit      <= '0;
      AN         <= 4'b1111;
      Cathodes   <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      if (cpu_we) cpu_reg <= cpu_val;
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) digit <= digit + 2'd1;
      // cpu_reg here is the pre-edge value, so a boundary write waits a frame.
      if (boundary) shown <= sel_dbg ? dbg_val : cpu_reg;
      frame_done <= boundary;
      AN         <= an_nx;
      Cathodes   <= cat_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Randomised bench for seg_scan_controller against a frame-position model.
// Honours SEG_LEADING_ZERO_BLANK_EN the same way the design does.
module tb_seg_scan_controller;

  localparam int SD = 4;
  localparam int FR = 4 * SD;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_val = '0;
  logic        cpu_we = 1'b0;
  logic [15:0] dbg_val = '0;
  logic        sel_dbg = 1'b0;
  logic [7:0]  Cathodes;
  logic [3:0]  AN;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  int          k = 0;
  logic [15:0] m_cpu = '0;
  logic [15:0] m_shown = '0;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03,
                                7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_controller #(.SCAN_DIV(SD)) dut (
    .sysclk(sysclk),
    .reset(reset),
    .cpu_val(cpu_val),
    .cpu_we(cpu_we),
    .dbg_val(dbg_val),
    .sel_dbg(sel_dbg),
    .Cathodes(Cathodes),
    .AN(AN),
    .frame_done(frame_done)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  function automatic logic lz_blank(input logic [15:0] v, input int d);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    return (d > 0) && ((v >> (4 * d)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    logic [3:0] ean;
    logic [7:0] ecat;
    logic       efd;
    int         pos;
    int         d;
    int         ph;
    if (reset) begin
      ean = 4'hF; ecat = 8'hFF; efd = 1'b0;
      m_cpu = '0; m_shown = '0; k = 0;
    end else begin
      pos = k % FR;
      d = pos / SD;
      ph = pos % SD;
      efd = (pos == FR - 1);
      if (ph == 0) begin
        ean = 4'hF; ecat = 8'hFF;
      end else begin
        ean = ~(4'(1) << d);
        if (lz_blank(m_shown, d)) ecat = 8'hFF;
        else ecat = {1'b1, seg_tab[(m_shown >> (4 * d)) & 16'hF]};
      end
      if (efd) m_shown = sel_dbg ? dbg_val : m_cpu;
      if (cpu_we) m_cpu = cpu_val;
      k++;
    end
    @(posedge sysclk);
    #1;
    chk("an", 16'(AN), 16'(ean));
    chk("cathodes", 16'(Cathodes), 16'(ecat));
    chk("frame_done", 16'(frame_done), 16'(efd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FR && (k % FR) != pos; i++) tick();
  endtask

  task automatic write(input logic [15:0] v);
    cpu_val = v; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(20);
    run_to(6);
    write(16'h1234);
    run(32);
    dbg_val = 16'hBEEF;
    run_to(5);
    sel_dbg = 1'b1;
    run(32);
    sel_dbg = 1'b0;
    run_to(FR - 1);
    write(16'h00AA);
    run(48);
    run_to(9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(20);
    write(16'h0050);
    run(40);
    write(16'h0000);
    run(40);
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      cpu_we = ($urandom_range(0, 7) == 0);
      cpu_val = 16'($urandom) & 16'(16'hFFFF >> (4 * $urandom_range(0, 3)));
      if ($urandom_range(0, 19) == 0) sel_dbg = ~sel_dbg;
      if ($urandom_range(0, 9) == 0)
        dbg_val = 16'($urandom) & 16'(16'hFFFF >> (4 * $urandom_range(0, 3)));
      tick();
    end
    reset = 1'b0;
    cpu_we = 1'b0;
    run(16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Display-side controller for the board's 4-digit 7-segment display.
- Time-multiplexes one shared Cathodes bus across the four anodes.
- Arbitrates which 16-bit value is shown: the CPU-written display register, or a debug value selected by a switch.
- Swaps the source and the value only at frame boundaries, so a frame never shows a mix of two values. Sits between the CPU datapath/peripheral bus and the board pins.

Parameters:
- SCAN_DIV, 100000, sysclk cycles per digit dwell (1 ms at 100 MHz). Minimum 2. Benches use 4.

Ports:
- sysclk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- cpu_val  input  16  display data from CPU store
- cpu_we  input  1  one-cycle write strobe for cpu_val
- dbg_val  input  16  debug value (e.g. PC low half)
- sel_dbg  input  1  0 = CPU register source, 1 = dbg_val source
- Cathodes  output  8  active-low segments; [7] = DP, [6:0] = {g,f,e,d,c,b,a}
- AN  output  4  active-low digit enables; AN[0] = rightmost digit
- frame_done  output  1  one-cycle pulse at end of each 4-digit frame

Behaviour:
- Reset: cpu_reg=0, shown=0, div_cnt=0, digit=0. Registered outputs AN=4'b1111, Cathodes=8'hFF, frame_done=0.
- cpu_reg: loads cpu_val on any cycle with cpu_we=1. It is not shown until the next frame boundary.
- div_cnt: counts 0..SCAN_DIV-1, then wraps to 0. On wrap, digit advances 0→1→2→3→0.
- Frame boundary: the cycle where digit==3 and div_cnt==SCAN_DIV-1.
  - frame_done=1 on the next edge, for exactly one cycle.
  - On that same edge: shown <= sel_dbg ? dbg_val : cpu_reg.
  - A simultaneous cpu_we on the boundary cycle is not visible in the new frame; it takes effect one frame later.
  - sel_dbg and dbg_val are sampled only at the boundary. Changes mid-frame have no visible effect until then.
- Outputs are registered. The value at edge t+1 is a function of the state at t.
  - div_cnt==0 (anti-ghost blank cycle): AN=4'b1111, Cathodes=8'hFF.
  - Otherwise: AN=~(4'b0001<<digit), Cathodes={1'b1, seg(shown[4*digit+3:4*digit])}.
- seg() table, hex 0..F, active-low: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E. DP is always off.
- Timing:
  - Frame period: 4*SCAN_DIV cycles.
  - Each digit is lit for SCAN_DIV-1 cycles after 1 blank cycle.
  - Nothing is lit in the first cycle after reset is released.
- Reset mid-frame: the next edge forces the reset values, and scanning restarts at digit 0 with div_cnt=0.
- Widths: div_cnt is $clog2(SCAN_DIV) bits; digit is 2 bits with natural wrap.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit d (3..1) is blanked (Cathodes=8'hFF, AN still driven active for that dwell) when the nibbles of shown at d and every higher digit are all zero.
  - Digit 0 is never blanked, so 0 displays as a single "0".
- Undefined: all four digits are always shown as hex, with leading zeros.

Test Plan:
- Reset, then run one frame (SCAN_DIV=4):
  - First cycle after reset: AN=1111, Cathodes=FF.
  - Each digit dwell: 1 cycle AN=1111, then 3 cycles AN=1110/1101/1011/0111 with Cathodes=8'hC0.
  - frame_done pulses once every 16 cycles.
- cpu_we with cpu_val=16'h1234 mid-frame, sel_dbg=0:
  - Current frame still shows 0000.
  - The frame after frame_done shows digit0 8'h99, digit1 8'hB0, digit2 8'hA4, digit3 8'hF9.
- cpu_reg=16'h1234, dbg_val=16'hBEEF, sel_dbg toggled 0→1 at digit 1:
  - No change until the boundary.
  - Next frame shows digit0 F (8'h8E), E (8'h86), E (8'h86), b (8'h83).
- cpu_we asserted exactly on the boundary cycle with 16'h00AA: the next frame shows the previous value, and the frame after shows 00AA.
- Reset asserted during digit 2: next edge gives AN=1111, Cathodes=FF, frame_done=0. After release, scan restarts at digit 0 and shown=0000.
- shown=16'h0050:
  - With SEG_LEADING_ZERO_BLANK_EN: digits 3,2 give Cathodes=FF with AN active, digit1 8'h92, digit0 8'hC0.
  - Without the macro: digits 3,2 show 8'hC0.
